fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the pipelined RISC-V core. It owns the program counter and sequences instruction-memory requests through a req/gnt/rvalid handshake, one request outstanding at a time. It presents fetched instructions to decode through a one-entry valid/ready output register. It also applies trap and branch/jump redirects, flushing and discarding stale fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- TRAP_VEC, 32'h0000_0100, fetch target when trap_valid is asserted.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_gnt.
- imem_addr  out  32  fetch address; equals PC at all times.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken from execute.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- trap_valid  in  1  trap; target TRAP_VEC; beats redirect.
- inst_valid  out  1  output register holds a live instruction.
- inst_ready  in  1  decode consumes the instruction (low = stall).
- inst_code  out  32  instruction word.
- inst_pc  out  32  address of inst_code.

## Operation
- State machine BOOT → REQ ⇄ WAIT. Internal regs: pc, req_pc, discard, out_valid.
- Reset (reset_n low, async): state=BOOT, pc=RESET_PC, discard=0, inst_valid=0, inst_code=0, inst_pc=0, imem_req=0.
- BOOT: imem_req=0 for one cycle, then REQ.
- REQ:
  - imem_req=1 only when slot free, i.e. !inst_valid || inst_ready.
  - On imem_req && imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with discard=1: drop the data, clear discard, go to REQ.
  - On imem_rvalid with discard=0: inst_code<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go to REQ.
- Output slot: inst_valid && inst_ready clears inst_valid unless it is refilled the same cycle. The slot is always empty when rvalid arrives, guaranteed by the REQ issue rule.
- Redirect/trap (either input high):
  - Target is TRAP_VEC if trap_valid, else {redirect_pc[31:2],2'b00}.
  - pc<=target and inst_valid<=0 (flush) on the same edge.
  - This overrides pc+4, any same-cycle output load and any same-cycle consumption.
  - In WAIT: discard<=1; if rvalid arrives in the same cycle, that data is dropped and discard stays 0.
  - In REQ with gnt in the same cycle: go to WAIT with discard=1; pc<=target, not pc+4.
  - In BOOT: pc<=target.
- imem_rvalid outside WAIT (e.g. after reset mid-fetch) is ignored.

## Timing
- Fetch latency: address on imem_addr in cycle N; gnt in N → rvalid earliest N+1 → inst_valid high from N+2.
- Peak throughput: one instruction per 2 cycles with single-cycle memory.
- Redirect asserted in cycle N: imem_addr=target from N+1; first target instruction on inst_valid no earlier than N+3.
- imem_req and imem_addr are stable until gnt, except that a redirect changes imem_addr; no requirement is placed on memory about aborted unaccepted requests.
- All state changes happen on the rising clock edge, except reset, which takes effect immediately.

## Test plan
- Reset then single-cycle memory with gnt=1, inst_ready=1 → imem_addr 0,4,8,… on alternate cycles; inst_pc 0x0,0x4,0x8 with matching inst_code; first inst_valid 3 cycles after reset_n rises.
- Decode stall: hold inst_ready=0 with inst_valid=1 for 5 cycles → imem_req=0, inst_code/inst_pc unchanged; release → next fetch at inst_pc+4.
- Redirect in WAIT: redirect_pc=0x0000_0203 while waiting for the fetch of 0x8 → rdata for 0x8 dropped, next imem_addr=0x200, inst_pc=0x200.
- Trap and redirect in the same cycle (redirect_pc=0x40) → imem_addr=0x100 (TRAP_VEC); inst_valid cleared on the next edge.
- Redirect coincident with gnt in REQ → returning data discarded, imem_addr=target, no inst_valid for the stale PC.
- reset_n pulsed low during WAIT, then rvalid arrives → data ignored, restart at RESET_PC; pc wrap: redirect to 0xFFFF_FFFC, fetch → next imem_addr=0x0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time,
// and hands fetched words to decode through a one-entry valid/ready slot.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] target;
  logic        discard;
  logic        out_valid;
  logic        flush;
  logic        grant;
  logic        accept;
  logic        load;

  assign flush      = redirect_valid || trap_valid;
  // Masking keeps the target word-aligned regardless of the low bits supplied.
  assign target     = trap_valid ? TRAP_VEC : (redirect_pc & ~32'h0000_0003);
  assign load       = accept && !discard && !flush;
  assign imem_addr  = pc;
  assign inst_valid = out_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    grant      = 1'b0;
    accept     = 1'b0;
    case (state)
      BOOT: next_state = REQ;
      REQ: begin
        // Only issue when the output slot is guaranteed free by the time data returns.
        imem_req = !out_valid || inst_ready;
        if (imem_req && imem_gnt) begin
          grant      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          accept     = 1'b1;
          next_state = REQ;
        end
      end
      default: next_state = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      discard   <= 1'b0;
      out_valid <= 1'b0;
      inst_code <= 32'h0000_0000;
      inst_pc   <= 32'h0000_0000;
    end else begin
      if (flush) begin
        pc <= target;
      end else if (grant) begin
        pc <= pc + 32'd4;
      end

      // A response arriving with a redirect is dropped outright, so discard stays clear.
      if (accept) begin
        discard <= 1'b0;
      end else if (flush && (state == WAIT || grant)) begin
        discard <= 1'b1;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
      end else if (out_valid && inst_ready) begin
        out_valid <= 1'b0;
      end

      if (load) begin
        inst_code <= imem_rdata;
        inst_pc   <= req_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (grant) begin
      req_pc <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-configurable memory model
// and an in-order scoreboard of instructions expected at the decode handshake.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] sb[$];

  bit          gnt_en = 1'b1;
  int          lat    = 0;
  bit          pend   = 1'b0;
  int          cnt    = 0;
  logic [31:0] pend_addr = 32'h0;

  fetch_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] code_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responds between edges: rvalid lat cycles after the grant cycle.
  always @(negedge clock) begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = code_of(pend_addr);
        pend        = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    imem_gnt = gnt_en;
    if (imem_req && gnt_en && !pend) begin
      pend      = 1'b1;
      cnt       = lat;
      pend_addr = imem_addr;
    end
  end

  // Decode-side handshake monitor.
  always @(negedge clock) begin
    logic [63:0] got;
    logic [63:0] exp;
    if (reset_n && inst_valid && inst_ready && !redirect_valid && !trap_valid) begin
      got   = {inst_pc, inst_code};
      exp   = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      total = total + 1;
      assert (got === exp) begin
        passed = passed + 1;
      end else begin
        $error("FAIL consume observed pc/code=%h required=%h", got, exp);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (inst_valid !== 1'b1 && n < max) begin
      tick();
      n = n + 1;
    end
    check(tag, {63'd0, inst_valid}, 64'd1);
  endtask

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, code_of(a)};
  endfunction

  initial begin
    reset_n        = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    trap_valid     = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_req",   {63'd0, imem_req},   64'd0);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_code",  {32'd0, inst_code},  64'd0);
    check("rst_pc",    {32'd0, inst_pc},    64'd0);
    check("rst_addr",  {32'd0, imem_addr},  64'd0);
    tick(2);

    // Streaming fetch with single-cycle memory
    sb.push_back(ent(32'h0));
    sb.push_back(ent(32'h4));
    reset_n = 1'b1;
    tick();
    check("boot_req",  {63'd0, imem_req},   64'd1);
    check("addr0",     {32'd0, imem_addr},  64'h0);
    tick();
    check("wait_req",  {63'd0, imem_req},   64'd0);
    check("addr4",     {32'd0, imem_addr},  64'h4);
    check("lat_valid", {63'd0, inst_valid}, 64'd0);
    tick();
    check("first_valid", {63'd0, inst_valid}, 64'd1);
    check("first_pc",    {32'd0, inst_pc},    64'h0);
    tick(2);
    check("second_pc", {32'd0, inst_pc},   64'h4);
    check("addr8",     {32'd0, imem_addr}, 64'h8);

    // Decode stall
    inst_ready = 1'b0;
    #1;
    check("stall_req0", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req",   {63'd0, imem_req},   64'd0);
      check("stall_valid", {63'd0, inst_valid}, 64'd1);
      check("stall_pc",    {32'd0, inst_pc},    64'h4);
      check("stall_code",  {32'd0, inst_code},  {32'd0, code_of(32'h4)});
    end
    lat        = 2;
    inst_ready = 1'b1;
    #1;
    check("release_req",  {63'd0, imem_req},  64'd1);
    check("release_addr", {32'd0, imem_addr}, 64'h8);
    tick();

    // Redirect while waiting for 0x8 with slow memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    lat            = 0;
    check("redir_addr", {32'd0, imem_addr}, 64'h200);
    check("redir_req",  {63'd0, imem_req},  64'd0);
    wait_valid("redir_timeout", 10);
    check("redir_pc", {32'd0, inst_pc}, 64'h200);

    // Trap and redirect together flush a held instruction
    inst_ready     = 1'b0;
    gnt_en         = 1'b0;
    trap_valid     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    check("pre_trap_valid", {63'd0, inst_valid}, 64'd1);
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    check("trap_addr",  {32'd0, imem_addr},  64'h100);
    check("trap_flush", {63'd0, inst_valid}, 64'd0);
    check("trap_req",   {63'd0, imem_req},   64'd1);

    // Redirect coincident with grant
    gnt_en         = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    check("gnt_redir_addr", {32'd0, imem_addr},  64'h300);
    check("gnt_redir_req",  {63'd0, imem_req},   64'd0);
    sb.push_back(ent(32'h300));
    tick();
    check("stale_dropped", {63'd0, inst_valid}, 64'd0);
    wait_valid("gnt_redir_timeout", 10);
    check("gnt_redir_pc", {32'd0, inst_pc}, 64'h300);
    gnt_en = 1'b0;
    tick();

    // Reset during WAIT, stale response afterwards
    lat    = 3;
    gnt_en = 1'b1;
    tick();
    reset_n = 1'b0;
    gnt_en  = 1'b0;
    #1;
    check("midrst_req",   {63'd0, imem_req},   64'd0);
    check("midrst_valid", {63'd0, inst_valid}, 64'd0);
    check("midrst_addr",  {32'd0, imem_addr},  64'h0);
    tick();
    reset_n = 1'b1;
    tick(5);
    check("stale_ignored", {63'd0, inst_valid}, 64'd0);
    check("restart_addr",  {32'd0, imem_addr},  64'h0);
    check("restart_req",   {63'd0, imem_req},   64'd1);
    sb.push_back(ent(32'h0));
    lat    = 0;
    gnt_en = 1'b1;
    wait_valid("restart_timeout", 10);
    check("restart_pc", {32'd0, inst_pc}, 64'h0);
    gnt_en = 1'b0;
    tick();

    // PC wrap, with unaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_target", {32'd0, imem_addr}, 64'hFFFF_FFFC);
    sb.push_back(ent(32'hFFFF_FFFC));
    gnt_en = 1'b1;
    wait_valid("wrap_timeout", 10);
    check("wrap_pc",   {32'd0, inst_pc},   64'hFFFF_FFFC);
    check("wrap_addr", {32'd0, imem_addr}, 64'h0);
    gnt_en = 1'b0;
    tick(2);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
